// File: rtl/mult_error_accumulator.sv
// rtl/mult_error_accumulator.sv - batch accuracy scorer for a candidate multiplier
module mult_error_accumulator #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 16,
    parameter int SUM_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_samples,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   p,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_W-1:0]     sample_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [SUM_W-1:0]     err_sum,
    output logic [2*WIDTH-1:0]   err_max
);
    localparam int PW = 2 * WIDTH;
    // One spare bit above the wider of sum/diff so the add can never wrap before saturation.
    localparam int EW = ((SUM_W > PW) ? SUM_W : PW) + 1;
    localparam logic [EW-1:0] SUM_MAX = EW'({SUM_W{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_n, r_acc_cnt, r_sample_count, r_err_count;
    logic               r_v1;
    logic [PW-1:0]      r_exact, r_p, r_err_max;
    logic [SUM_W-1:0]   r_err_sum;

    logic               w_start_ok, w_accept, w_last;
    logic [PW-1:0]      w_exact, w_diff;
    logic [EW-1:0]      w_sum_ext;
    logic [CNT_W-1:0]   w_acc_inc;

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);
    assign in_ready   = (r_state == RUN) && (r_acc_cnt < r_n);
    assign w_accept   = in_valid && in_ready;
    assign w_acc_inc  = r_acc_cnt + CNT_W'(1);
    assign w_last     = w_accept && (w_acc_inc == r_n);
    assign w_exact    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_diff     = (r_exact >= r_p) ? (r_exact - r_p) : (r_p - r_exact);
    assign w_sum_ext  = EW'(r_err_sum) + EW'(w_diff);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = (num_samples == '0) ? DONE : RUN;
            RUN:        if (w_last) w_next = DRAIN;
            DRAIN:      if (!r_v1) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_n            <= '0;
            r_acc_cnt      <= '0;
            r_v1           <= 1'b0;
            r_exact        <= '0;
            r_p            <= '0;
            r_sample_count <= '0;
            r_err_count    <= '0;
            r_err_sum      <= '0;
            r_err_max      <= '0;
        end else begin
            r_state <= w_next;
            r_v1    <= w_accept;
            if (w_accept) begin
                r_exact   <= w_exact;
                r_p       <= p;
                r_acc_cnt <= w_acc_inc;
            end
            if (w_start_ok) begin
                r_n            <= num_samples;
                r_acc_cnt      <= '0;
                r_sample_count <= '0;
                r_err_count    <= '0;
                r_err_sum      <= '0;
                r_err_max      <= '0;
            end else if (r_v1) begin
                r_sample_count <= r_sample_count + CNT_W'(1);
                if (w_diff != '0) r_err_count <= r_err_count + CNT_W'(1);
                r_err_sum <= (w_sum_ext > SUM_MAX) ? SUM_MAX[SUM_W-1:0] : w_sum_ext[SUM_W-1:0];
                if (w_diff > r_err_max) r_err_max <= w_diff;
            end
        end
    end

    assign busy         = (r_state == RUN) || (r_state == DRAIN);
    assign done         = (r_state == DONE);
    assign sample_count = r_sample_count;
    assign err_count    = r_err_count;
    assign err_sum      = r_err_sum;
    assign err_max      = r_err_max;
endmodule

// File: tb/tb_mult_error_accumulator.sv
// tb/tb_mult_error_accumulator.sv - directed bench for mult_error_accumulator
module tb_mult_error_accumulator;
    logic        clk = 1'b0;
    logic        rst_n, start, in_valid;
    logic [15:0] num_samples;
    logic [1:0]  a, b;
    logic [3:0]  p;

    logic        in_ready, busy, done;
    logic [15:0] sample_count, err_count;
    logic [23:0] err_sum;
    logic [3:0]  err_max;

    logic        s_in_ready, s_busy, s_done;
    logic [15:0] s_sample_count, s_err_count;
    logic [3:0]  s_err_sum;
    logic [3:0]  s_err_max;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mult_error_accumulator #(.WIDTH(2), .CNT_W(16), .SUM_W(24)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .p(p),
        .busy(busy), .done(done), .sample_count(sample_count), .err_count(err_count),
        .err_sum(err_sum), .err_max(err_max)
    );

    mult_error_accumulator #(.WIDTH(2), .CNT_W(16), .SUM_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .p(p),
        .busy(s_busy), .done(s_done), .sample_count(s_sample_count), .err_count(s_err_count),
        .err_sum(s_err_sum), .err_max(s_err_max)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_samples = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] ia, input logic [1:0] ib, input logic [3:0] ip);
        int guard = 0;
        a = ia; b = ib; p = ip;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        n_vec++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!done && guard < 100) begin
            tick();
            guard++;
        end
        n_vec++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL wait_done done=%0b required=1", done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_vec++;
        if ({in_ready, busy, done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags ready/busy/done=%b required=000", {in_ready, busy, done});
        end
        n_vec++;
        if ({sample_count, err_count, err_sum, err_max} !== '0) begin
            n_bad++; $display("FAIL reset_metrics sc=%0d ec=%0d sum=%0d max=%0d required all 0",
                              sample_count, err_count, err_sum, err_max);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_exact();
        do_start(16'd5);
        n_vec++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL exact_busy busy=%0b ready=%0b required 1 1", busy, in_ready);
        end
        send(2'd2, 2'd2, 4'd4);
        send(2'd3, 2'd1, 4'd3);
        send(2'd1, 2'd1, 4'd1);
        send(2'd1, 2'd3, 4'd3);
        send(2'd3, 2'd3, 4'd9);
        n_vec++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL exact_lat0 done=%0b required=0", done); end
        tick();
        n_vec++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL exact_lat1 done=%0b required=0", done); end
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL exact_lat2 done=%0b busy=%0b required 1 0", done, busy);
        end
        n_vec++;
        if (sample_count !== 16'd5 || err_count !== 16'd0 || err_sum !== 24'd0 || err_max !== 4'd0) begin
            n_bad++; $display("FAIL exact_metrics sc=%0d ec=%0d sum=%0d max=%0d required 5 0 0 0",
                              sample_count, err_count, err_sum, err_max);
        end
    endtask

    task automatic test_faulty();
        do_start(16'd4);
        send(2'd3, 2'd3, 4'd8);
        send(2'd2, 2'd3, 4'd6);
        send(2'd2, 2'd2, 4'd0);
        send(2'd1, 2'd2, 4'd3);
        wait_done();
        n_vec++;
        if (sample_count !== 16'd4 || err_count !== 16'd3 || err_sum !== 24'd6 || err_max !== 4'd4) begin
            n_bad++; $display("FAIL faulty_metrics sc=%0d ec=%0d sum=%0d max=%0d required 4 3 6 4",
                              sample_count, err_count, err_sum, err_max);
        end
    endtask

    task automatic test_zero_batch();
        do_start(16'd0);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL zero_flags done=%0b busy=%0b ready=%0b required 1 0 0", done, busy, in_ready);
        end
        n_vec++;
        if ({sample_count, err_count, err_sum, err_max} !== '0) begin
            n_bad++; $display("FAIL zero_metrics sc=%0d ec=%0d sum=%0d max=%0d required all 0",
                              sample_count, err_count, err_sum, err_max);
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL zero_hold done=%0b busy=%0b required 1 0", done, busy);
        end
    endtask

    task automatic test_gaps();
        logic [5:0] pat;
        int k;
        pat = 6'b101001;
        k = 0;
        do_start(16'd3);
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i];
            a = 2'(k + 1); b = 2'd2; p = 4'(2 * (k + 1));
            if (pat[i]) k++;
            tick();
        end
        in_valid = 1'b0;
        n_vec++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL gaps_ready in_ready=%0b required=0", in_ready); end
        in_valid = 1'b1; a = 2'd3; b = 2'd3; p = 4'd0;
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (done !== 1'b1) begin n_bad++; $display("FAIL gaps_done done=%0b required=1", done); end
        n_vec++;
        if (sample_count !== 16'd3 || err_count !== 16'd0 || err_max !== 4'd0) begin
            n_bad++; $display("FAIL gaps_metrics sc=%0d ec=%0d max=%0d required 3 0 0",
                              sample_count, err_count, err_max);
        end
    endtask

    task automatic test_saturation();
        do_start(16'd2);
        send(2'd3, 2'd3, 4'd0);
        send(2'd3, 2'd3, 4'd0);
        wait_done();
        n_vec++;
        if (s_err_sum !== 4'd15 || s_err_max !== 4'd9 || s_err_count !== 16'd2 || s_done !== 1'b1) begin
            n_bad++; $display("FAIL sat_small sum=%0d max=%0d ec=%0d done=%0b required 15 9 2 1",
                              s_err_sum, s_err_max, s_err_count, s_done);
        end
        n_vec++;
        if (err_sum !== 24'd18 || err_max !== 4'd9) begin
            n_bad++; $display("FAIL sat_wide sum=%0d max=%0d required 18 9", err_sum, err_max);
        end
    endtask

    task automatic test_abort_restart();
        do_start(16'd5);
        send(2'd3, 2'd3, 4'd0);
        send(2'd2, 2'd2, 4'd1);
        rst_n = 1'b0;
        tick();
        n_vec++;
        if ({in_ready, busy, done} !== 3'b000 || {sample_count, err_count, err_sum, err_max} !== '0) begin
            n_bad++; $display("FAIL abort_clear ready/busy/done=%b sc=%0d ec=%0d sum=%0d max=%0d required all 0",
                              {in_ready, busy, done}, sample_count, err_count, err_sum, err_max);
        end
        rst_n = 1'b1;
        tick();
        do_start(16'd1);
        do_start(16'd7);
        send(2'd2, 2'd1, 4'd2);
        n_vec++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL abort_relatch in_ready=%0b required=0", in_ready); end
        wait_done();
        n_vec++;
        if (sample_count !== 16'd1 || err_count !== 16'd0 || err_sum !== 24'd0) begin
            n_bad++; $display("FAIL abort_metrics sc=%0d ec=%0d sum=%0d required 1 0 0",
                              sample_count, err_count, err_sum);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        num_samples = '0; a = '0; b = '0; p = '0;
        test_reset();
        test_exact();
        test_faulty();
        test_zero_batch();
        test_gaps();
        test_saturation();
        test_abort_restart();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
